// File: rtl/uart_tx_fifo.sv
// Transmit FIFO between the system-side writer and the UART transmitter.
// Head word is presented registered on out_data; the transmitter pops it with tx_done.
module uart_tx_fifo #(
    parameter int unsigned            DATA_WIDTH = 8,
    parameter int unsigned            AW         = 4,
    parameter logic [DATA_WIDTH-1:0]  IDLE_WORD  = {DATA_WIDTH{1'b1}}
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  tx_done,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  tx_start,
    output logic                  full,
    output logic                  empty,
    output logic [AW:0]           count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned CW    = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wp;
    logic [AW-1:0]         rp;
    logic [AW-1:0]         rp_next;
    logic [CW-1:0]         count_next;
    logic [DATA_WIDTH-1:0] out_next;
    logic                  push_acc;
    logic                  pop_acc;
    logic                  overflow_next;
    logic                  underflow_next;

    // Accept/drop decisions and the post-edge view of the queue.
    always_comb begin
        push_acc       = wr_en && (!full || tx_done);
        pop_acc        = tx_done && !empty;
        rp_next        = pop_acc ? rp + AW'(1) : rp;
        count_next     = count + CW'(push_acc) - CW'(pop_acc);
        overflow_next  = overflow;
        underflow_next = underflow;
        out_next       = IDLE_WORD;

        if (clr_err) begin
            overflow_next  = 1'b0;
            underflow_next = 1'b0;
        end
        // A new error in the same cycle as clr_err takes precedence.
        if (wr_en && full && !tx_done) begin
            overflow_next = 1'b1;
        end
        if (tx_done && empty) begin
            underflow_next = 1'b1;
        end

        if (count_next == '0) begin
            out_next = IDLE_WORD;
        end else if (count == '0 && push_acc) begin
            out_next = wr_data;
        end else if (push_acc && wp == rp_next) begin
            out_next = wr_data;
        end else begin
            out_next = mem[rp_next];
        end
    end

    // Storage array; contents are meaningless after reset so it carries none.
    always_ff @(posedge clock) begin
        if (push_acc) begin
            mem[wp] <= wr_data;
        end
    end

    // Pointers, occupancy and registered status.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wp        <= '0;
            rp        <= '0;
            count     <= '0;
            out_data  <= IDLE_WORD;
            tx_start  <= 1'b0;
            full      <= 1'b0;
            empty     <= 1'b1;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_acc) begin
                wp <= wp + AW'(1);
            end
            rp        <= rp_next;
            count     <= count_next;
            out_data  <= out_next;
            tx_start  <= (count_next != '0);
            full      <= (count_next == CW'(DEPTH));
            empty     <= (count_next == '0);
            overflow  <= overflow_next;
            underflow <= underflow_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed vector table, corner sequences,
// and random traffic against a queue-based reference model.
module tb_uart_tx_fifo;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;

    logic          clock;
    logic          reset;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          tx_done;
    logic          clr_err;
    logic [DW-1:0] out_data;
    logic          tx_start;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DW-1:0] q[$];
    logic          m_ov;
    logic          m_uf;

    uart_tx_fifo #(.DATA_WIDTH(DW), .AW(AW)) dut (
        .clock     (clock),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .tx_done   (tx_done),
        .clr_err   (clr_err),
        .out_data  (out_data),
        .tx_start  (tx_start),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic          wr;
        logic [DW-1:0] data;
        logic          td;
        logic          clr;
        int            exp_count;
        logic [DW-1:0] exp_out;
        logic          exp_ov;
        logic          exp_uf;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ov = 1'b0;
        m_uf = 1'b0;
    endtask

    // Behavioural rules: drop when full (unless popping), ignore pop when empty.
    task automatic model_step(input logic wr, input logic [DW-1:0] d, input logic td, input logic clr);
        int  n;
        logic was_full, was_empty;
        n         = q.size();
        was_full  = (n == DEPTH);
        was_empty = (n == 0);
        if (clr) begin
            m_ov = 1'b0;
            m_uf = 1'b0;
        end
        if (wr && was_full && !td) m_ov = 1'b1;
        if (td && was_empty)       m_uf = 1'b1;
        if (td && !was_empty)      void'(q.pop_front());
        if (wr && (!was_full || td)) q.push_back(d);
    endtask

    task automatic check_model(input string tag);
        int n;
        logic [DW-1:0] head;
        n    = q.size();
        head = (n > 0) ? q[0] : 8'hFF;
        check({tag, ".out_data"},  int'(out_data),  int'(head));
        check({tag, ".count"},     int'(count),     n);
        check({tag, ".tx_start"},  int'(tx_start),  int'(n != 0));
        check({tag, ".full"},      int'(full),      int'(n == DEPTH));
        check({tag, ".empty"},     int'(empty),     int'(n == 0));
        check({tag, ".overflow"},  int'(overflow),  int'(m_ov));
        check({tag, ".underflow"}, int'(underflow), int'(m_uf));
    endtask

    task automatic cycle(input logic wr, input logic [DW-1:0] d, input logic td, input logic clr,
                         input string tag);
        @(negedge clock);
        wr_en   = wr;
        wr_data = d;
        tx_done = td;
        clr_err = clr;
        @(posedge clock);
        model_step(wr, d, td, clr);
        #1;
        check_model(tag);
        wr_en   = 1'b0;
        tx_done = 1'b0;
        clr_err = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        #2;
        check_model("reset");
        @(negedge clock);
        reset = 1'b1;
    endtask

    vec_t vecs[6];

    initial begin
        reset   = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        tx_done = 1'b0;
        clr_err = 1'b0;
        model_reset();

        vecs[0] = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 8'hFF, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1, 8'hA5, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 8'hFF, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 8'h3C, 1'b1, 1'b0, 1, 8'h3C, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1, 8'h3C, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 8'hFF, 1'b0, 1'b0};

        #12;
        check_model("por");
        @(negedge clock);
        reset = 1'b1;

        // Directed vector table
        for (int i = 0; i < 6; i++) begin
            cycle(vecs[i].wr, vecs[i].data, vecs[i].td, vecs[i].clr, $sformatf("vec%0d", i));
            check($sformatf("vec%0d.tbl_count", i), int'(count),     vecs[i].exp_count);
            check($sformatf("vec%0d.tbl_out", i),   int'(out_data),  int'(vecs[i].exp_out));
            check($sformatf("vec%0d.tbl_ov", i),    int'(overflow),  int'(vecs[i].exp_ov));
            check($sformatf("vec%0d.tbl_uf", i),    int'(underflow), int'(vecs[i].exp_uf));
        end

        // Fill, overflow, clear, full push+pop, drain
        do_reset();
        for (int i = 1; i <= 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, "fill");
        check("fill.full_hard", int'(full), 1);
        check("fill.count_hard", int'(count), 16);
        cycle(1'b1, 8'h11, 1'b0, 1'b0, "drop");
        check("drop.overflow_hard", int'(overflow), 1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, "clr");
        cycle(1'b1, 8'h55, 1'b1, 1'b0, "fullpp");
        check("fullpp.count_hard", int'(count), 16);
        check("fullpp.head_hard", int'(out_data), 8'h02);
        for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, "drain");
        check("drain.idle_hard", int'(out_data), 8'hFF);

        // Async reset mid-burst with 7 words queued
        for (int i = 0; i < 7; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, "burst");
        check("burst.count_hard", int'(count), 7);
        @(posedge clock);
        #3;
        reset = 1'b0;
        model_reset();
        #1;
        check_model("async_rst");
        @(negedge clock);
        reset = 1'b1;
        cycle(1'b1, 8'h99, 1'b0, 1'b0, "post_rst");
        check("post_rst.head_hard", int'(out_data), 8'h99);

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic wr, td, clr;
            int   mode;
            mode = i / 500;
            wr   = ($urandom_range(0, 99) < ((mode % 2 == 0) ? 70 : 35));
            td   = ($urandom_range(0, 99) < ((mode % 2 == 0) ? 35 : 70));
            clr  = ($urandom_range(0, 99) < 5);
            cycle(wr, 8'($urandom), td, clr, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised transmit FIFO sitting between the system-side writer and the UART transmitter, generalising the one-word TX interface buffer to DEPTH words of DATA_WIDTH bits. The writer pushes words with a single-cycle strobe; the transmitter sees the head word on out_data with tx_start high, and pops it by pulsing tx_done when transmission ends. Adds full/empty/occupancy status and sticky overflow/underflow error flags, so bursts of words can be queued without waiting for each frame to finish.

## Interface
- DATA_WIDTH, 8, bits per word.
- AW, 4, address width; DEPTH = 2**AW words (AW >= 1).
- IDLE_WORD, all ones ({DATA_WIDTH{1'b1}}), value driven on out_data while empty (line-idle pattern).
- clock  in  1  main system clock (50 MHz); all state changes on rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- wr_en  in  1  push request; wr_data captured on the rising edge where high.
- wr_data  in  DATA_WIDTH  word to queue.
- tx_done  in  1  pop request from transmitter; current head word is finished.
- clr_err  in  1  synchronous clear of overflow and underflow.
- out_data  out  DATA_WIDTH  head word presented to transmitter; IDLE_WORD when empty.
- tx_start  out  1  high while at least one word is queued (inverse of empty).
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  AW+1  number of queued words, 0..DEPTH.
- overflow  out  1  sticky: a push was dropped because FIFO was full.
- underflow  out  1  sticky: tx_done arrived while FIFO was empty.

## Operation
- Storage: DEPTH x DATA_WIDTH array, write pointer wp and read pointer rp (AW bits each), both wrap modulo DEPTH (DEPTH-1 -> 0); count register of AW+1 bits.
- Push accepted when wr_en && (!full || tx_done): mem[wp] <= wr_data, wp <= wp+1.
- Pop accepted when tx_done && !empty: rp <= rp+1.
- count_next = count + push_acc - pop_acc; simultaneous accepted push+pop leaves count unchanged.
- Full with wr_en && tx_done: both accepted, count stays DEPTH, no overflow.
- Full with wr_en && !tx_done: word dropped, no state change except overflow <= 1.
- Empty with tx_done (with or without wr_en): pop ignored, underflow <= 1; a simultaneous wr_en is still accepted (count -> 1).
- clr_err clears overflow/underflow; if a new error occurs in the same cycle, set wins.
- out_data, tx_start, full, empty are registered and reflect post-edge state:
  - count_next == 0: out_data <= IDLE_WORD, tx_start <= 0.
  - count == 0 and push accepted: out_data <= wr_data (write-through, no extra cycle).
  - otherwise: out_data <= mem[rp_next] (mem[rp] if no pop, mem[rp+1] on pop; if that slot is being written this cycle, use wr_data).
- No state machine beyond pointer/count control; status is a pure function of count_next.

## Timing
- Reset (asynchronous assert, any time including mid-burst): wp=rp=0, count=0, out_data=IDLE_WORD, tx_start=0, full=0, empty=1, overflow=0, underflow=0. Stored words lost. Deassertion is synchronised externally.
- Push latency: word written at edge N into empty FIFO is on out_data with tx_start=1 after edge N (same as the one-word buffer).
- Pop latency: tx_done at edge N -> next head word (or IDLE_WORD/tx_start=0) on out_data after edge N; transmitter must sample only after that edge.
- tx_done is a single-cycle pulse per word; held high for k cycles pops k words.
- Status flags and count update on the same edge as the push/pop causing them.

## Test plan
- Reset then idle: out_data=8'hFF, tx_start=0, empty=1, count=0, all flags 0.
- Push 8'hA5 into empty: next cycle out_data=8'hA5, tx_start=1, count=1; pulse tx_done -> out_data=8'hFF, tx_start=0, empty=1.
- Push 0x01..0x10 (DEPTH=16) back-to-back: full=1 after 16th edge, count=16; push 0x11 -> dropped, overflow=1; pop 16 times -> out_data sequence 0x01..0x10 in order, then 8'hFF; wp/rp wrapped to 0.
- Full FIFO, wr_en+tx_done same cycle with 0x55: count stays 16, overflow stays 0, 0x55 emerges as 16th word after head.
- Empty FIFO, tx_done with wr_en=0x3C: underflow=1, count=1, out_data=0x3C; clr_err -> underflow=0.
- Reset asserted asynchronously mid-burst with count=7: outputs immediately return to reset values; subsequent push 0x99 appears as head.
